// File: rtl/pcileech_bar_regfile_pkg.sv
// Shared types and helpers for the table-driven BAR register-file emulator.
package pcileech_bar_regfile_pkg;

    typedef enum logic [2:0] {
        RO  = 3'd0,
        RW  = 3'd1,
        RC  = 3'd2,
        W1C = 3'd3,
        SEQ = 3'd4
    } reg_mode_t;

    localparam int CTX_W        = 88;
    localparam int NUM_REGS_MAX = 64;

    // BAR-relative byte offset; bit 2 of the BAR register is a type flag, not address.
    function automatic logic [31:0] bar_offset(
        input logic [31:0] addr,
        input logic [31:0] bar,
        input logic [31:0] mask
    );
        return (addr - (bar & ~32'h4)) & mask;
    endfunction

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) begin
                m[i*8 +: 8] = 8'hFF;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pcileech_bar_impl_regfile_addr_decode.sv
// Offset-to-register decoder: one-hot hit vector, lowest index wins on duplicate offsets.
module pcileech_bar_addr_decode
    import pcileech_bar_regfile_pkg::*;
#(
    parameter int unsigned               NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0][11:0] REG_OFFSET = '0
) (
    input  logic [31:0]         offset,
    output logic [NUM_REGS-1:0] hit_vec,
    output logic                hit
);

    if (NUM_REGS < 1 || NUM_REGS > NUM_REGS_MAX) begin : g_bad_num_regs
        $error("NUM_REGS out of range");
    end

    // Low two address bits are ignored on both sides of the compare.
    always_comb begin
        hit_vec = '0;
        hit     = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (!hit && ((offset | 32'h3) == {20'h0, REG_OFFSET[i][11:2], 2'b11})) begin
                hit_vec[i] = 1'b1;
                hit        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcileech_bar_impl_regfile.sv
// Table-driven BAR register file with a fixed 2-cycle read latency.
// Optional SEQ-mode read sequencing is built only when PCILEECH_BAR_SEQ_EN is defined.
module pcileech_bar_impl_regfile
    import pcileech_bar_regfile_pkg::*;
#(
    parameter int unsigned                              NUM_REGS   = 16,
    parameter logic [31:0]                              ADDR_MASK  = 32'h7FF,
    parameter logic [NUM_REGS-1:0][11:0]                REG_OFFSET = '0,
    parameter logic [NUM_REGS-1:0][31:0]                REG_RESET  = '0,
    parameter logic [NUM_REGS-1:0][31:0]                REG_WMASK  = '0,
    parameter logic [NUM_REGS-1:0][2:0]                 REG_MODE   = '0,
    parameter logic [NUM_REGS-1:0][31:0]                REG_AUX    = '0,
    parameter int unsigned                              SEQ_DEPTH  = 4,
    parameter logic [NUM_REGS-1:0][SEQ_DEPTH-1:0][31:0] SEQ_TABLE  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      wr_addr,
    input  logic [3:0]       wr_be,
    input  logic [31:0]      wr_data,
    input  logic             wr_valid,
    input  logic [CTX_W-1:0] rd_req_ctx,
    input  logic [31:0]      rd_req_addr,
    input  logic             rd_req_valid,
    input  logic [31:0]      base_address_register,
    output logic [CTX_W-1:0] rd_rsp_ctx,
    output logic [31:0]      rd_rsp_data,
    output logic             rd_rsp_valid
);

    if (SEQ_DEPTH < 2 || SEQ_DEPTH > 16 || (SEQ_DEPTH & (SEQ_DEPTH - 1)) != 0) begin : g_bad_seq_depth
        $error("SEQ_DEPTH must be a power of two in 2..16");
    end
    if ($bits(SEQ_TABLE) != NUM_REGS * SEQ_DEPTH * 32) begin : g_bad_seq_table
        $error("SEQ_TABLE size does not match NUM_REGS x SEQ_DEPTH");
    end

    logic [31:0]               rd_off;
    logic [31:0]               wr_off;
    logic [NUM_REGS-1:0]       rd_sel;
    logic [NUM_REGS-1:0]       wr_sel;
    logic                      rd_hit;
    logic                      wr_hit;

    logic                      rd_s1_valid;
    logic                      rd_s1_hit;
    logic [CTX_W-1:0]          rd_s1_ctx;
    logic [NUM_REGS-1:0]       rd_s1_sel;
    logic                      wr_s1_valid;
    logic [NUM_REGS-1:0]       wr_s1_sel;
    logic [31:0]               wr_s1_data;
    logic [31:0]               wr_s1_mask;

    logic [NUM_REGS-1:0][31:0] regs;
    logic [31:0]               rd_mux;

`ifdef PCILEECH_BAR_SEQ_EN
    localparam int unsigned SEQ_W = $clog2(SEQ_DEPTH);
    logic [NUM_REGS-1:0][SEQ_W-1:0] seq_idx;
`endif

    // The BAR is folded in at request time so a BAR change only affects later requests.
    assign rd_off = bar_offset(rd_req_addr, base_address_register, ADDR_MASK);
    assign wr_off = bar_offset(wr_addr, base_address_register, ADDR_MASK);

    pcileech_bar_addr_decode #(
        .NUM_REGS   (NUM_REGS),
        .REG_OFFSET (REG_OFFSET)
    ) u_rd_decode (
        .offset  (rd_off),
        .hit_vec (rd_sel),
        .hit     (rd_hit)
    );

    pcileech_bar_addr_decode #(
        .NUM_REGS   (NUM_REGS),
        .REG_OFFSET (REG_OFFSET)
    ) u_wr_decode (
        .offset  (wr_off),
        .hit_vec (wr_sel),
        .hit     (wr_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_s1_valid <= 1'b0;
            rd_s1_hit   <= 1'b0;
            rd_s1_ctx   <= '0;
            rd_s1_sel   <= '0;
            wr_s1_valid <= 1'b0;
            wr_s1_sel   <= '0;
            wr_s1_data  <= '0;
            wr_s1_mask  <= '0;
        end else begin
            rd_s1_valid <= rd_req_valid;
            rd_s1_hit   <= rd_req_valid & rd_hit;
            rd_s1_ctx   <= rd_req_ctx;
            rd_s1_sel   <= rd_sel;
            wr_s1_valid <= wr_valid & wr_hit;
            wr_s1_sel   <= wr_sel;
            wr_s1_data  <= wr_data;
            wr_s1_mask  <= be_to_mask(wr_be);
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_s1_sel[i]) begin
`ifdef PCILEECH_BAR_SEQ_EN
                if (reg_mode_t'(REG_MODE[i]) == SEQ) begin
                    rd_mux = rd_mux | SEQ_TABLE[i][seq_idx[i]];
                end else begin
                    rd_mux = rd_mux | regs[i];
                end
`else
                rd_mux = rd_mux | regs[i];
`endif
            end
        end
    end

    // Response is registered from the pre-update register values, so a read
    // sampled alongside a write observes the old contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_rsp_valid <= 1'b0;
            rd_rsp_data  <= '0;
            rd_rsp_ctx   <= '0;
        end else begin
            rd_rsp_valid <= rd_s1_valid;
            rd_rsp_data  <= (rd_s1_valid && rd_s1_hit) ? rd_mux : '0;
            rd_rsp_ctx   <= rd_s1_valid ? rd_s1_ctx : '0;
        end
    end

    // A write hitting a register takes priority over that register's read side effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= REG_RESET;
`ifdef PCILEECH_BAR_SEQ_EN
            seq_idx <= '0;
`endif
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (wr_s1_valid && wr_s1_sel[i]) begin
                    case (reg_mode_t'(REG_MODE[i]))
                        RW, RC: regs[i] <= (regs[i] & ~(REG_WMASK[i] & wr_s1_mask))
                                         | (wr_s1_data & REG_WMASK[i] & wr_s1_mask);
                        W1C:    regs[i] <= regs[i] & ~(wr_s1_data & REG_WMASK[i] & wr_s1_mask);
`ifdef PCILEECH_BAR_SEQ_EN
                        SEQ:    seq_idx[i] <= '0;
`endif
                        default: ;
                    endcase
                end else if (rd_s1_valid && rd_s1_sel[i]) begin
                    case (reg_mode_t'(REG_MODE[i]))
                        RC:  regs[i] <= REG_AUX[i];
`ifdef PCILEECH_BAR_SEQ_EN
                        SEQ: seq_idx[i] <= seq_idx[i] + SEQ_W'(1);
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
